// File: rtl/ssram_initiator_if.sv
// Core-side request/response channels of the synchronous SRAM initiator.
interface ssram_initiator_if #(
  parameter int unsigned DATA_LEN = 64,
  parameter int unsigned ADDR_LEN = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_LEN-1:0]   req_addr;
  logic [DATA_LEN/8-1:0] req_be;
  logic [DATA_LEN-1:0]   req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_LEN-1:0]   resp_rdata;
  logic                  resp_we;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_we, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_we, resp_err
  );
endinterface

// File: rtl/ssram_initiator.sv
// Valid/ready to one-cycle-latency synchronous SRAM adapter with a 2-entry
// in-order response buffer and credit-based request flow control.
module ssram_initiator #(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned DATA_LEN  = 64,
  parameter int unsigned ADDR_LEN  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  ssram_initiator_if.slave             core_if,
  output logic                         mem_cs_o,
  output logic                         mem_we_o,
  output logic [DATA_LEN/8-1:0]        mem_be_o,
  output logic [$clog2(NUM_WORDS)-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0]          mem_wdata_o,
  input  logic [DATA_LEN-1:0]          mem_rdata_i
);
  localparam int unsigned OFF = $clog2(DATA_LEN/8);
  localparam int unsigned AW  = $clog2(NUM_WORDS);

  typedef struct packed {
    logic valid;
    logic we;
    logic err;
  } pend_t;

  typedef struct packed {
    logic [DATA_LEN-1:0] rdata;
    logic                we;
    logic                err;
  } entry_t;

  logic         misaligned, out_of_range, err, acc, pop;
  logic [2:0]   credit;
  pend_t        pend_q, pend_d;
  entry_t [1:0] ent_q, ent_d;
  entry_t       push_ent;
  logic [1:0]   count_q, count_d;

  assign misaligned = |core_if.req_addr[OFF-1:0];

  generate
    if (ADDR_LEN > OFF + AW) begin : g_oor
      assign out_of_range = |core_if.req_addr[ADDR_LEN-1:OFF+AW];
    end else begin : g_no_oor
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign err = misaligned | out_of_range;

  // Credit counts the response still in the SRAM pipe, so a full FIFO can
  // always absorb it; popping this cycle frees a slot combinationally.
  assign credit            = {1'b0, count_q} + {2'b00, pend_q.valid} - {2'b00, pop};
  assign core_if.req_ready = (credit < 3'd2);
  assign acc               = core_if.req_valid & core_if.req_ready;

  assign mem_cs_o    = acc & ~err;
  assign mem_we_o    = core_if.req_we & mem_cs_o;
  assign mem_be_o    = core_if.req_we ? core_if.req_be : '0;
  assign mem_addr_o  = core_if.req_addr[OFF +: AW];
  assign mem_wdata_o = core_if.req_wdata;

  assign core_if.resp_valid = (count_q != 2'd0);
  assign core_if.resp_rdata = ent_q[0].rdata;
  assign core_if.resp_we    = ent_q[0].we;
  assign core_if.resp_err   = ent_q[0].err;
  assign pop                = core_if.resp_valid & core_if.resp_ready;

  always_comb begin
    pend_d       = '0;
    pend_d.valid = acc;
    pend_d.we    = core_if.req_we;
    pend_d.err   = err;
  end

  always_comb begin
    push_ent       = '0;
    push_ent.rdata = (~pend_q.we & ~pend_q.err) ? mem_rdata_i : '0;
    push_ent.we    = pend_q.we;
    push_ent.err   = pend_q.err;
  end

  // Slot 0 is always the head; pop shifts first, then a push lands in the
  // first free slot of the shifted buffer.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (pop) begin
      ent_d[0] = ent_q[1];
      count_d  = count_q - 2'd1;
    end
    if (pend_q.valid) begin
      ent_d[count_d[0]] = push_ent;
      count_d           = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end
endmodule
